// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Main control FSM of the multi-cycle RV32I core. Sequences
//            FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared ALU,
//            register file and memory ports, owns the instruction register,
//            and traps on illegal opcodes or memory-port timeouts.
// Ports    : clk/rst_n          clock, synchronous active-low reset
//            imem_*             instruction fetch handshake and data
//            dmem_*             data memory handshake (req/we/ready)
//            branch_taken       comparator result, sampled in EXEC
//            alu_a_sel/alu_b_sel/wb_sel/pc_sel   datapath mux selects
//            reg_we/pc_we       register-file and PC write enables
//            retire/instret     retirement pulse and retired count
//            trap/trap_cause    sticky trap flag and its cause
//            inst/state         instruction register and debug state
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    input  logic                 branch_taken,
    output logic [1:0]           alu_a_sel,
    output logic                 alu_b_sel,
    output logic [1:0]           wb_sel,
    output logic                 reg_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] c_CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] c_CAUSE_DMEM    = 2'd3;

    // Trap fires on the edge that ends the MEM_TIMEOUT-th unanswered cycle.
    localparam logic [15:0] c_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t                 r_state;
    logic [15:0]            r_wait;
    logic [31:0]            r_inst;
    logic [INSTRET_W-1:0]   r_instret;
    logic                   r_trap;
    logic [1:0]             r_cause;

    logic [6:0] w_opc;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_legal;
    logic       w_timeout;

    assign w_opc       = r_inst[6:0];
    assign w_is_load   = (w_opc == c_OPC_LOAD);
    assign w_is_store  = (w_opc == c_OPC_STORE);
    assign w_is_branch = (w_opc == c_OPC_BRANCH);
    assign w_is_jump   = (w_opc == c_OPC_JAL) || (w_opc == c_OPC_JALR);
    assign w_legal     = (w_opc == c_OPC_OP)    || (w_opc == c_OPC_OP_IMM) ||
                         (w_opc == c_OPC_LUI)   || (w_opc == c_OPC_AUIPC)  ||
                         w_is_jump || w_is_branch || w_is_load || w_is_store;
    assign w_timeout   = (r_wait == c_WAIT_LAST);

    assign inst       = r_inst;
    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign state      = r_state;

    // Datapath controls. Everything is forced low while rst_n is held so a
    // reset that lands mid-access drops the request immediately.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_a_sel = 2'd0;
        alu_b_sel = 1'b0;
        wb_sel    = 2'd0;
        reg_we    = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        retire    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: imem_req = 1'b1;
                S_EXEC: begin
                    alu_b_sel = (w_opc != c_OPC_OP);
                    if (w_opc == c_OPC_LUI) begin
                        alu_a_sel = 2'd2;
                    end else if ((w_opc == c_OPC_AUIPC) || (w_opc == c_OPC_JAL) || w_is_branch) begin
                        alu_a_sel = 2'd1;
                    end
                    if (w_is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    if (dmem_ready && w_is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    pc_sel = w_is_jump;
                    if (w_is_jump) begin
                        wb_sel = 2'd2;
                    end else if (w_is_load) begin
                        wb_sel = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= 16'd0;
            r_inst    <= 32'd0;
            r_instret <= '0;
            r_trap    <= 1'b0;
            r_cause   <= 2'd0;
        end else begin
            if (retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_inst  <= imem_rdata;
                        r_state <= S_DECODE;
                        r_wait  <= 16'd0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_IMEM;
                        r_wait  <= 16'd0;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_DECODE: begin
                    r_wait <= 16'd0;
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    r_wait <= 16'd0;
                    if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else if (w_is_branch) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_state <= w_is_store ? S_FETCH : S_WB;
                        r_wait  <= 16'd0;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= c_CAUSE_DMEM;
                        r_wait  <= 16'd0;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= 16'd0;
                end
                S_TRAP: begin
                    r_wait <= 16'd0;
                end
                // Unused encodings 6/7 are treated as corruption.
                default: begin
                    r_state <= S_TRAP;
                    r_trap  <= 1'b1;
                    r_cause <= c_CAUSE_ILLEGAL;
                    r_wait  <= 16'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        branch_taken;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        pc_we;
    logic        pc_sel;
    logic        retire;
    logic [3:0]  instret;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MEM_TIMEOUT(4), .INSTRET_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
        .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .retire(retire), .instret(instret),
        .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a word with imem_ready for one FETCH cycle; ends in DECODE.
    task automatic do_fetch(input logic [31:0] w);
        imem_rdata = w;
        imem_ready = 1'b1;
        #1;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        #1;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (inst !== 32'd0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst); end
        total++; if (instret !== 4'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        total++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin bad++; $display("FAIL reset_trap got=%b/%0d exp=0/0", trap, trap_cause); end
        total++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc_we !== 1'b0) begin bad++; $display("FAIL reset_enables got=%b%b%b exp=000", imem_req, dmem_req, pc_we); end
        rst_n = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || state !== 3'd0) begin bad++; $display("FAIL post_reset_fetch got=%b/%0d exp=1/0", imem_req, state); end
    endtask

    task automatic test_addi;
        do_fetch(32'h00500093);
        total++; if (state !== 3'd1 || inst !== 32'h00500093) begin bad++; $display("FAIL addi_decode got=%0d/%h exp=1/00500093", state, inst); end
        imem_rdata = 32'hDEADBEEF;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        total++; if (state !== 3'd2 || inst !== 32'h00500093) begin bad++; $display("FAIL addi_exec_state got=%0d/%h exp=2/00500093", state, inst); end
        total++; if (alu_a_sel !== 2'd0 || alu_b_sel !== 1'b1) begin bad++; $display("FAIL addi_exec_sel got=%0d/%b exp=0/1", alu_a_sel, alu_b_sel); end
        tick();
        total++; if (state !== 3'd4 || reg_we !== 1'b1 || wb_sel !== 2'd0 || retire !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0)
            begin bad++; $display("FAIL addi_wb got st=%0d we=%b wb=%0d ret=%b pcwe=%b pcs=%b exp 4/1/0/1/1/0", state, reg_we, wb_sel, retire, pc_we, pc_sel); end
        total++; if (instret !== 4'd0) begin bad++; $display("FAIL addi_instret_early got=%0d exp=0", instret); end
        tick();
        total++; if (state !== 3'd0 || instret !== 4'd1) begin bad++; $display("FAIL addi_done got=%0d/%0d exp=0/1", state, instret); end
    endtask

    task automatic test_load;
        do_fetch(32'h0000A103);
        tick();
        total++; if (state !== 3'd2 || alu_a_sel !== 2'd0 || alu_b_sel !== 1'b1) begin bad++; $display("FAIL lw_exec got=%0d/%0d/%b exp=2/0/1", state, alu_a_sel, alu_b_sel); end
        tick();
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            #1;
            total++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || reg_we !== 1'b0)
                begin bad++; $display("FAIL lw_mem_cycle%0d got st=%0d req=%b we=%b exp 3/1/0", k, state, dmem_req, dmem_we); end
            tick();
        end
        dmem_ready = 1'b0;
        total++; if (state !== 3'd4 || wb_sel !== 2'd1 || reg_we !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL lw_wb got=%0d/%0d/%b exp=4/1/1", state, wb_sel, reg_we); end
        tick();
        total++; if (state !== 3'd0 || instret !== 4'd2) begin bad++; $display("FAIL lw_done got=%0d/%0d exp=0/2", state, instret); end
    endtask

    task automatic test_branch;
        for (int t = 1; t >= 0; t--) begin
            do_fetch(32'h00000463);
            tick();
            branch_taken = (t == 1);
            #1;
            total++; if (state !== 3'd2 || pc_we !== 1'b1 || pc_sel !== branch_taken || retire !== 1'b1)
                begin bad++; $display("FAIL beq_exec_t%0d got st=%0d pcwe=%b pcs=%b ret=%b", t, state, pc_we, pc_sel, retire); end
            total++; if (reg_we !== 1'b0 || dmem_we !== 1'b0 || alu_a_sel !== 2'd1 || alu_b_sel !== 1'b1)
                begin bad++; $display("FAIL beq_sel_t%0d got we=%b a=%0d b=%b exp 0/1/1", t, reg_we, alu_a_sel, alu_b_sel); end
            tick();
            branch_taken = 1'b0;
            total++; if (state !== 3'd0) begin bad++; $display("FAIL beq_next_t%0d got=%0d exp=0", t, state); end
        end
        total++; if (instret !== 4'd4) begin bad++; $display("FAIL beq_instret got=%0d exp=4", instret); end
    endtask

    task automatic test_illegal;
        do_fetch(32'hFFFFFFFF);
        tick();
        total++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd1) begin bad++; $display("FAIL illegal_trap got=%0d/%b/%0d exp=5/1/1", state, trap, trap_cause); end
        imem_rdata = 32'h00500093;
        imem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            total++; if (imem_req !== 1'b0 || state !== 3'd5 || pc_we !== 1'b0) begin bad++; $display("FAIL trap_hold%0d got req=%b st=%0d", k, imem_req, state); end
            tick();
        end
        imem_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        total++; if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0 || instret !== 4'd0)
            begin bad++; $display("FAIL illegal_reset got st=%0d trap=%b cause=%0d ir=%0d", state, trap, trap_cause, instret); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_timeout;
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (state !== 3'd0 || trap !== 1'b0) begin bad++; $display("FAIL imem_wait%0d got=%0d/%b exp=0/0", k, state, trap); end
            tick();
        end
        total++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd2) begin bad++; $display("FAIL imem_timeout got=%0d/%b/%0d exp=5/1/2", state, trap, trap_cause); end
        pulse_reset();
        do_fetch(32'h0020A023);
        tick();
        tick();
        dmem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || trap !== 1'b0)
                begin bad++; $display("FAIL dmem_wait%0d got st=%0d req=%b we=%b", k, state, dmem_req, dmem_we); end
            tick();
        end
        total++; if (state !== 3'd5 || trap !== 1'b1 || trap_cause !== 2'd3 || dmem_req !== 1'b0)
            begin bad++; $display("FAIL dmem_timeout got=%0d/%b/%0d exp=5/1/3", state, trap, trap_cause); end
        pulse_reset();
    endtask

    task automatic test_jal_mix;
        do_fetch(32'h008000EF);
        tick();
        total++; if (alu_a_sel !== 2'd1 || alu_b_sel !== 1'b1) begin bad++; $display("FAIL jal_exec got=%0d/%b exp=1/1", alu_a_sel, alu_b_sel); end
        tick();
        total++; if (state !== 3'd4 || wb_sel !== 2'd2 || pc_sel !== 1'b1 || reg_we !== 1'b1) begin bad++; $display("FAIL jal_wb got st=%0d wb=%0d pcs=%b we=%b", state, wb_sel, pc_sel, reg_we); end
        tick();
        do_fetch(32'h00500093);
        tick();
        tick();
        tick();
        do_fetch(32'h0020A023);
        tick();
        tick();
        dmem_ready = 1'b1;
        #1;
        total++; if (retire !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 1'b0 || reg_we !== 1'b0 || dmem_we !== 1'b1)
            begin bad++; $display("FAIL sw_mem got ret=%b pcwe=%b pcs=%b we=%b dwe=%b", retire, pc_we, pc_sel, reg_we, dmem_we); end
        tick();
        dmem_ready = 1'b0;
        total++; if (state !== 3'd0 || instret !== 4'd3) begin bad++; $display("FAIL sw_done got=%0d/%0d exp=0/3", state, instret); end
        do_fetch(32'h0020A023);
        tick();
        tick();
        total++; if (state !== 3'd3 || dmem_req !== 1'b1) begin bad++; $display("FAIL sw2_mem got=%0d/%b exp=3/1", state, dmem_req); end
        rst_n = 1'b0;
        #1;
        total++; if (dmem_req !== 1'b0 || pc_we !== 1'b0) begin bad++; $display("FAIL midreset_gate got=%b/%b exp=0/0", dmem_req, pc_we); end
        tick();
        total++; if (state !== 3'd0 || instret !== 4'd0 || dmem_req !== 1'b0 || inst !== 32'd0)
            begin bad++; $display("FAIL midreset_state got st=%0d ir=%0d req=%b inst=%h", state, instret, dmem_req, inst); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 15; i++) begin
            do_fetch(32'h00000463);
            tick();
            branch_taken = 1'b1;
            tick();
            branch_taken = 1'b0;
        end
        total++; if (instret !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", instret); end
        do_fetch(32'h00000463);
        tick();
        tick();
        total++; if (instret !== 4'd0 || state !== 3'd0) begin bad++; $display("FAIL wrap_post got=%0d/%0d exp=0/0", instret, state); end
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'd0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        tick();
        tick();
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_illegal();
        test_timeout();
        test_jal_mix();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences instruction fetch, decode, execute, memory access and write-back over the shared ALU, register file and memory ports. It owns the instruction register, which feeds the immediate generator and register-file address decode. It drives all datapath mux selects and write enables, and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 255, maximum cycles to wait for imem_ready/dmem_ready before a bus-error trap; legal range 1..65535.
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  core clock; all state changes on its rising edge.
rst_n  input  1  reset, synchronous, active-low.
imem_req  output  1  instruction fetch request.
imem_ready  input  1  fetch data valid this cycle.
imem_rdata  input  32  fetched instruction word.
inst  output  32  instruction register, to the immediate generator and decode.
dmem_req  output  1  data memory request.
dmem_we  output  1  1 = store, 0 = load; valid while dmem_req is high.
dmem_ready  input  1  data access complete this cycle.
branch_taken  input  1  branch comparator result from the datapath; sampled in EXEC.
alu_a_sel  output  2  0 = rs1, 1 = pc, 2 = zero.
alu_b_sel  output  1  0 = rs2, 1 = immediate.
wb_sel  output  2  0 = ALU out register, 1 = load data, 2 = pc+4.
reg_we  output  1  register-file write enable.
pc_we  output  1  PC write enable.
pc_sel  output  1  0 = pc+4, 1 = ALU out register (target).
retire  output  1  one-cycle pulse when an instruction completes.
instret  output  INSTRET_W  count of retired instructions; wraps at all-ones.
trap  output  1  sticky trap flag.
trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.
state  output  3  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Encodings 6 and 7 go to TRAP next cycle with cause 1.
- Reset (rst_n low at a rising edge): state=FETCH, inst=0, instret=0, trap=0, trap_cause=0, wait counter=0. All enables and selects are 0, including when reset is asserted mid-access. An in-flight request is abandoned.
- Outputs are combinational from state and inst, except inst, instret, trap and trap_cause, which are registered.
- FETCH:
  - Assert imem_req.
  - If imem_ready: load inst from imem_rdata, go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches MEM_TIMEOUT without ready, go to TRAP with cause 2.
  - The counter clears on every state entry.
- DECODE: one cycle, no enables.
  - Legal opcodes: OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011.
  - Any other value of inst[6:0] goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC: one cycle; selects per opcode.
  - OP: a=0, b=0.
  - OP_IMM, LOAD, STORE, JALR: a=0, b=1.
  - LUI: a=2, b=1.
  - AUIPC, JAL: a=1, b=1.
  - BRANCH: a=1, b=1 (target computed into the ALU out register); see the next item for completion.
  - Next state: LOAD/STORE go to MEM; BRANCH completes in EXEC; all others go to WB.
- BRANCH in EXEC: pc_we=1, pc_sel=branch_taken, retire=1, next state FETCH.
- MEM:
  - Assert dmem_req; dmem_we=1 for STORE.
  - On dmem_ready: LOAD goes to WB. STORE asserts pc_we=1, pc_sel=0, retire=1 in that same cycle and goes to FETCH.
  - Timeout goes to TRAP with cause 3, same counting rule as FETCH.
- WB:
  - reg_we=1 and pc_we=1.
  - wb_sel: 2 for JAL/JALR, 1 for LOAD, else 0.
  - pc_sel: 1 for JAL/JALR, else 0.
  - retire=1; next state FETCH.
- TRAP: all enables 0, trap=1, trap_cause held, no further fetch. Only rst_n exits TRAP.
- instret increments on each retire cycle and is visible the next cycle; it wraps to 0 after all-ones.
- Cycle counts with zero wait states: OP/OP_IMM/LUI/AUIPC/JAL/JALR = 4, BRANCH = 3, STORE = 4, LOAD = 5. Each wait cycle adds one.
- With MEM_TIMEOUT=N and ready never asserted: the trap is registered after exactly N cycles in FETCH or MEM.
- imem_ready/dmem_ready are ignored outside FETCH/MEM.
- reg_we and dmem_we are never asserted for BRANCH or STORE write-back.

Test Plan:
- Reset then fetch ADDI x1,x0,5 (0x00500093), imem_ready always high -> state sequence 0,1,2,4,0; alu_a_sel=0 and alu_b_sel=1 in EXEC; reg_we=1, wb_sel=0, retire=1 in cycle 4; instret=1.
- LW 0x0000A103 with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; then WB with wb_sel=1; total 8 cycles.
- BEQ 0x00000463 with branch_taken=1, then again with branch_taken=0 -> both retire in EXEC (3 cycles); pc_sel=1 then 0; reg_we never asserted.
- Word 0xFFFFFFFF -> TRAP after DECODE, trap_cause=1, imem_req stays low for 20 further cycles; rst_n low for one edge -> state=0, trap=0.
- MEM_TIMEOUT=4 with imem_ready held low -> trap=1, trap_cause=2 after 4 FETCH cycles; repeat for SW 0x0020A023 with dmem_ready low -> trap_cause=3.
- JAL 0x008000EF followed by 3 more instructions; rst_n pulsed low mid-MEM of a store -> WB of the JAL has wb_sel=2 and pc_sel=1; after the reset pulse dmem_req=0, instret=0, state=FETCH.
